// File: rtl/register_pipe_vr.sv
// register_pipe_vr: valid/ready register pipeline of DEPTH stages.
// Bubbles collapse: a beat moves into any empty stage ahead of it even
// while the output is stalled. With SKID=1 an extra input entry absorbs
// one beat, so in_ready comes straight from a flop instead of from the
// combinational ready chain. Occupancy counts every held beat.
module register_pipe_vr #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID      = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
  output logic [$clog2(DEPTH+SKID+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + SKID + 1);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [OCC_W-1:0] r_occ;

  logic [DEPTH-1:0] w_can;
  logic [DEPTH-1:0] w_ld_vld;
  logic [WIDTH-1:0] w_ld_data [DEPTH];
  logic             w_src_vld;
  logic [WIDTH-1:0] w_src_data;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Flush hides the output beat so no transfer can happen on a flush edge.
  assign out_valid  = r_vld[DEPTH-1] & ~flush;
  assign out_data   = r_data[DEPTH-1];
  assign occupancy  = r_occ;
  assign w_out_xfer = out_valid & out_ready;
  assign w_in_xfer  = in_valid & in_ready;

  // Ready chain: a stage can load when empty or when its beat moves on.
  always_comb begin
    logic can_nxt;
    logic leave;
    logic can;
    w_can   = '0;
    leave   = w_out_xfer;
    can     = ~r_vld[DEPTH-1] | leave;
    w_can[DEPTH-1] = can;
    can_nxt = can;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      leave    = r_vld[k] & can_nxt;
      can      = ~r_vld[k] | leave;
      w_can[k] = can;
      can_nxt  = can;
    end
  end

  // Source offered to each stage: stage 0 from the input side, others from upstream.
  always_comb begin
    w_ld_vld = '0;
    for (int k = 0; k < DEPTH; k++) w_ld_data[k] = '0;
    w_ld_vld[0]  = w_src_vld;
    w_ld_data[0] = w_src_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_ld_vld[k]  = r_vld[k-1];
      w_ld_data[k] = r_data[k-1];
    end
  end

  // Stage registers; data changes only when a beat is actually loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) r_data[k] <= RESET_VAL;
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (w_can[k]) begin
          r_vld[k] <= w_ld_vld[k];
          if (w_ld_vld[k]) r_data[k] <= w_ld_data[k];
        end
      end
    end
  end

  // Held-beat counter: +1 per input transfer, -1 per output transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic             r_skid_vld;
      logic [WIDTH-1:0] r_skid_data;

      // Skid entry: catches a beat stage 0 cannot take; drains into stage 0 first.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_skid_vld  <= 1'b0;
          r_skid_data <= RESET_VAL;
        end else if (flush) begin
          r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
          if (w_can[0]) r_skid_vld <= 1'b0;
        end else if (w_in_xfer && !w_can[0]) begin
          r_skid_vld  <= 1'b1;
          r_skid_data <= in_data;
        end
      end

      assign in_ready   = ~r_skid_vld & ~flush;
      assign w_src_vld  = r_skid_vld | w_in_xfer;
      assign w_src_data = r_skid_vld ? r_skid_data : in_data;
    end else begin : g_noskid
      assign in_ready   = w_can[0] & ~flush;
      assign w_src_vld  = w_in_xfer;
      assign w_src_data = in_data;
    end
  endgenerate

endmodule

// File: tb/tb_register_pipe_vr.sv
// Bench for register_pipe_vr: two instances (SKID=0 and SKID=1, DEPTH=3)
// share one stimulus stream; each is checked every cycle against a
// slot-position queue model, plus a hand-computed vector table and
// directed sequences for latency, backpressure, flush and reset.
module tb_register_pipe_vr;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ir0, ov0, ir1, ov1;
  logic [7:0] od0, od1;
  logic [1:0] occ0;
  logic [2:0] occ1;

  register_pipe_vr #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'hA5), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(occ0));

  register_pipe_vr #(.WIDTH(8), .DEPTH(D), .RESET_VAL(8'hA5), .SKID(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(occ1));

  always #5 clk = ~clk;

  // Model: ordered beats, each with its slot (-1 = skid, D-1 = output slot).
  typedef struct { logic [7:0] d; int pos; } beat_t;
  beat_t q0[$];
  beat_t q1[$];
  beat_t mq[$];

  typedef struct {
    logic iv; logic [7:0] id; logic ordy; logic fl;
    logic eir; logic eov; logic [7:0] eod; int eocc;
  } vec_t;
  vec_t tbl[19];

  int n_cmp = 0;
  int n_bad = 0;
  logic s_ir0, s_ov0, s_ir1, s_ov1;
  logic [7:0] s_od0, s_od1;
  int s_occ0, s_occ1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock of movement: head leaves if allowed, every beat advances one
  // slot when the slot ahead is free. lim = lowest slot now occupied (D if none).
  task automatic settle(input logic ordy, output int lim);
    lim = D;
    if (ordy && mq.size() > 0 && mq[0].pos == D - 1) void'(mq.pop_front());
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].pos + 1 <= lim - 1) mq[i].pos = mq[i].pos + 1;
      lim = mq[i].pos;
    end
  endtask

  task automatic model_eval(input int skid, input logic ordy, input logic fl,
                            output logic ir, output logic ov, output logic [7:0] od,
                            output int occ);
    beat_t save[$];
    int lim;
    occ = mq.size();
    ov  = !fl && mq.size() > 0 && mq[0].pos == D - 1;
    od  = ov ? mq[0].d : 8'h00;
    if (fl) begin
      ir = 1'b0;
    end else if (skid != 0) begin
      ir = 1'b1;
      foreach (mq[i]) if (mq[i].pos < 0) ir = 1'b0;
    end else begin
      save = mq;
      settle(ordy, lim);
      mq = save;
      ir = (lim > 0);
    end
  endtask

  task automatic model_step(input int skid, input logic iv, input logic [7:0] id,
                            input logic ordy, input logic fl);
    logic ir, ov;
    logic [7:0] od;
    int occ, lim;
    beat_t b;
    if (fl) begin
      mq.delete();
    end else begin
      model_eval(skid, ordy, fl, ir, ov, od, occ);
      settle(ordy, lim);
      if (iv && ir) begin
        b.d   = id;
        b.pos = (lim > 0) ? 0 : -1;
        mq.push_back(b);
      end
    end
  endtask

  // Drive one cycle: inputs after the edge, check at negedge, advance models.
  task automatic tick(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    logic eir, eov;
    logic [7:0] eod;
    int eocc;
    in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(negedge clk);
    s_ir0 = ir0; s_ov0 = ov0; s_od0 = od0; s_occ0 = int'(occ0);
    s_ir1 = ir1; s_ov1 = ov1; s_od1 = od1; s_occ1 = int'(occ1);
    mq = q0;
    model_eval(0, ordy, fl, eir, eov, eod, eocc);
    chk("u0.in_ready", 32'(ir0), 32'(eir));
    chk("u0.out_valid", 32'(ov0), 32'(eov));
    if (eov) chk("u0.out_data", 32'(od0), 32'(eod));
    chk("u0.occupancy", 32'(occ0), 32'(eocc));
    model_step(0, iv, id, ordy, fl);
    q0 = mq;
    mq = q1;
    model_eval(1, ordy, fl, eir, eov, eod, eocc);
    chk("u1.in_ready", 32'(ir1), 32'(eir));
    chk("u1.out_valid", 32'(ov1), 32'(eov));
    if (eov) chk("u1.out_data", 32'(od1), 32'(eod));
    chk("u1.occupancy", 32'(occ1), 32'(eocc));
    model_step(1, iv, id, ordy, fl);
    q1 = mq;
    @(posedge clk); #1;
  endtask

  // Assert reset between edges and check its effect before any clock edge.
  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2; rst = 1'b1; #1;
    chk("rst.u0.out_valid", 32'(ov0), 32'd0);
    chk("rst.u0.out_data", 32'(od0), 32'hA5);
    chk("rst.u0.occupancy", 32'(occ0), 32'd0);
    chk("rst.u0.in_ready", 32'(ir0), 32'd1);
    chk("rst.u1.out_valid", 32'(ov1), 32'd0);
    chk("rst.u1.out_data", 32'(od1), 32'hA5);
    chk("rst.u1.occupancy", 32'(occ1), 32'd0);
    chk("rst.u1.in_ready", 32'(ir1), 32'd1);
    q0.delete(); q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int first, nxt, a0, a1, n0, n1;

    // Bubble collapse then flush, expected values for the SKID=0 instance.
    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 1};
    tbl[7]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 2};
    tbl[8]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 3};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 1};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[13] = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[14] = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1};
    tbl[15] = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2};
    tbl[16] = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3};
    tbl[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};
    tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0};

    @(posedge clk); #1;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("tbl[%0d].in_ready", i), 32'(s_ir0), 32'(tbl[i].eir));
      chk($sformatf("tbl[%0d].out_valid", i), 32'(s_ov0), 32'(tbl[i].eov));
      if (tbl[i].eov) chk($sformatf("tbl[%0d].out_data", i), 32'(s_od0), 32'(tbl[i].eod));
      chk($sformatf("tbl[%0d].occupancy", i), 32'(s_occ0), 32'(tbl[i].eocc));
    end

    // Streaming 01..10 with out_ready high: latency D, then 16 in-order beats.
    do_reset();
    first = -1; nxt = 1;
    for (int i = 0; i < 22; i++) begin
      tick(i < 16, 8'(i + 1), 1'b1, 1'b0);
      if (s_ov0) begin
        if (first < 0) first = i;
        chk("stream.order", 32'(s_od0), 32'(nxt));
        nxt++;
      end
      if (i == 10) chk("stream.occupancy", 32'(s_occ0), 32'd3);
    end
    chk("stream.first_valid", 32'(first), 32'(D));
    chk("stream.count", 32'(nxt - 1), 32'd16);

    // Reset mid-stream discards held beats.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    do_reset();

    // Backpressure: fill with out_ready low, then drain in order.
    a0 = 0; a1 = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
      a0 += int'(s_ir0);
      a1 += int'(s_ir1);
    end
    chk("bp.accepted0", 32'(a0), 32'd3);
    chk("bp.accepted1", 32'(a1), 32'd4);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("bp.occupancy0", 32'(s_occ0), 32'd3);
    chk("bp.occupancy1", 32'(s_occ1), 32'd4);
    chk("bp.in_ready0", 32'(s_ir0), 32'd0);
    chk("bp.in_ready1", 32'(s_ir1), 32'd0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      if (s_ov0) begin chk("bp.drain0", 32'(s_od0), 32'(8'h50 + n0)); n0++; end
      if (s_ov1) begin chk("bp.drain1", 32'(s_od1), 32'(8'h50 + n1)); n1++; end
    end
    chk("bp.drained0", 32'(n0), 32'd3);
    chk("bp.drained1", 32'(n1), 32'd4);

    // Simultaneous in and out transfer at occupancy 2.
    do_reset();
    tick(1'b1, 8'h61, 1'b0, 1'b0);
    tick(1'b1, 8'h62, 1'b0, 1'b0);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    tick(1'b1, 8'h63, 1'b1, 1'b0);
    chk("simul.pre_occupancy", 32'(s_occ0), 32'd2);
    chk("simul.pre_out_data", 32'(s_od0), 32'h61);
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    chk("simul.post_occupancy", 32'(s_occ0), 32'd2);
    chk("simul.post_out_data", 32'(s_od0), 32'h62);
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic against the model, with occasional flush and one reset.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      tick(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
